// File: rtl/cl_ddr_rd_arb.sv
// -----------------------------------------------------------------------------
// cl_ddr_rd_arb
//   AXI4 read-channel arbiter: merges NUM_MSTR read masters onto a single DDR
//   read port. AR requests are granted round-robin. Each master has a limit on
//   the number of bursts it may have outstanding. The master index is prepended
//   to ARID, and the R path uses those upper RID bits to route each beat back.
//
// Ports
//   clk, pipe_rst_n            clock, asynchronous active-low reset
//   s_ar{valid,ready,addr,id,len,size}
//                              per-master AR channels (flattened vectors)
//   s_r{valid,ready}           per-master R handshake
//   s_r{data,id,resp,last}     shared R payload; s_rid has the index stripped
//   m_ar{valid,ready,addr,id,len,size}
//                              DDR AR channel, m_arid = {index, s_arid}
//   m_r{valid,ready,data,id,resp,last}
//                              DDR R channel
//   route_err                  sticky flag: an R beat carried an index >= NUM_MSTR
//   perf_beats, perf_stall     per-master 32-bit performance counters
//
// Build option
//   RD_ARB_PERF_CNT_EN   when defined, perf_beats and perf_stall are live counters.
//                        When not defined, both outputs are tied to zero.
// -----------------------------------------------------------------------------
module cl_ddr_rd_arb #(
  parameter int NUM_MSTR  = 2,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int ID_W      = 6,
  parameter int MAX_OUTST = 16,
  localparam int IDX_W    = (NUM_MSTR > 1) ? $clog2(NUM_MSTR) : 1
) (
  input  logic                     clk,
  input  logic                     pipe_rst_n,
  input  logic [NUM_MSTR-1:0]      s_arvalid,
  output logic [NUM_MSTR-1:0]      s_arready,
  input  logic [NUM_MSTR*ADDR_W-1:0] s_araddr,
  input  logic [NUM_MSTR*ID_W-1:0] s_arid,
  input  logic [NUM_MSTR*8-1:0]    s_arlen,
  input  logic [NUM_MSTR*3-1:0]    s_arsize,
  output logic [NUM_MSTR-1:0]      s_rvalid,
  input  logic [NUM_MSTR-1:0]      s_rready,
  output logic [DATA_W-1:0]        s_rdata,
  output logic [ID_W-1:0]          s_rid,
  output logic [1:0]               s_rresp,
  output logic                     s_rlast,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [ADDR_W-1:0]        m_araddr,
  output logic [ID_W+IDX_W-1:0]    m_arid,
  output logic [7:0]               m_arlen,
  output logic [2:0]               m_arsize,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic [ID_W+IDX_W-1:0]    m_rid,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  output logic                     route_err,
  output logic [NUM_MSTR*32-1:0]   perf_beats,
  output logic [NUM_MSTR*32-1:0]   perf_stall
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;  // holds 0..MAX_OUTST

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state, state_next;
  logic [NUM_MSTR-1:0] arready_q, arready_next;
  logic [IDX_W-1:0]    grant_q, grant_next;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_next;
  logic [CNT_W-1:0]    outst [NUM_MSTR];
  logic [NUM_MSTR-1:0] eligible, pick_oh, ar_inc, r_dec;
  logic [IDX_W-1:0]    pick, idx;
  logic                pick_ok, idx_ok, load;
  logic [ADDR_W-1:0]   sel_addr;
  logic [ID_W-1:0]     sel_id;
  logic [7:0]          sel_len;
  logic [2:0]          sel_size;

  assign s_arready = arready_q;
  assign ar_inc    = arready_q & s_arvalid;
  assign r_dec     = s_rvalid & s_rready & {NUM_MSTR{m_rlast}};

  // Round-robin pick: first eligible master at or after rr_ptr.
  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_ok  = 1'b0;
    pick_oh  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_MSTR; i++)
      eligible[i] = s_arvalid[i] && (outst[i] < CNT_W'(MAX_OUTST));
    for (int k = 0; k < NUM_MSTR; k++) begin
      j = (int'(rr_ptr) + k) % NUM_MSTR;
      if (!pick_ok && eligible[j]) begin
        pick_ok = 1'b1;
        pick    = IDX_W'(j);
      end
    end
    for (int i = 0; i < NUM_MSTR; i++)
      pick_oh[i] = pick_ok && (pick == IDX_W'(i));
  end

  // The next grant is pre-selected while the current AR drains, so a new
  // ready pulse can follow m_arvalid&m_arready directly (2-cycle cadence).
  always_comb begin
    state_next   = state;
    arready_next = '0;
    grant_next   = grant_q;
    rr_ptr_next  = rr_ptr;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (|arready_q) begin
          // The ready pulse lasts one cycle whether or not it is taken.
          if (|ar_inc) begin
            load        = 1'b1;
            state_next  = ISSUE;
            rr_ptr_next = (grant_q == IDX_W'(NUM_MSTR - 1)) ? '0 : grant_q + 1'b1;
          end
        end else if (pick_ok) begin
          arready_next = pick_oh;
          grant_next   = pick;
        end
      end
      ISSUE: begin
        if (m_arready) begin
          state_next = IDLE;
          if (pick_ok) begin
            arready_next = pick_oh;
            grant_next   = pick;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      state     <= IDLE;
      arready_q <= '0;
      grant_q   <= '0;
      rr_ptr    <= '0;
      m_arvalid <= 1'b0;
    end else begin
      state     <= state_next;
      arready_q <= arready_next;
      grant_q   <= grant_next;
      rr_ptr    <= rr_ptr_next;
      if (load)
        m_arvalid <= 1'b1;
      else if (m_arready)
        m_arvalid <= 1'b0;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_id   = '0;
    sel_len  = '0;
    sel_size = '0;
    for (int i = 0; i < NUM_MSTR; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_addr = s_araddr[i*ADDR_W +: ADDR_W];
        sel_id   = s_arid[i*ID_W +: ID_W];
        sel_len  = s_arlen[i*8 +: 8];
        sel_size = s_arsize[i*3 +: 3];
      end
    end
  end

  // NOTE: the AR payload is qualified by m_arvalid, so these datapath flops need no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      m_araddr <= sel_addr;
      m_arid   <= {grant_q, sel_id};
      m_arlen  <= sel_len;
      m_arsize <= sel_size;
    end
  end

  // A grant and an rlast for the same master in one cycle cancel out.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      for (int i = 0; i < NUM_MSTR; i++) outst[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MSTR; i++) begin
        if (ar_inc[i] && !r_dec[i] && outst[i] != CNT_W'(MAX_OUTST))
          outst[i] <= outst[i] + 1'b1;
        else if (r_dec[i] && !ar_inc[i] && outst[i] != '0)
          outst[i] <= outst[i] - 1'b1;
      end
    end
  end

  // R routing is purely combinational. An unknown index is acked and dropped.
  assign idx     = m_rid[ID_W +: IDX_W];
  assign s_rdata = m_rdata;
  assign s_rid   = m_rid[ID_W-1:0];
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

  always_comb begin
    idx_ok   = 1'b0;
    m_rready = 1'b1;
    s_rvalid = '0;
    for (int i = 0; i < NUM_MSTR; i++) begin
      if (idx == IDX_W'(i)) begin
        idx_ok      = 1'b1;
        s_rvalid[i] = m_rvalid;
        m_rready    = s_rready[i];
      end
    end
  end

  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n)
      route_err <= 1'b0;
    else if (m_rvalid && !idx_ok)
      route_err <= 1'b1;
  end

`ifdef RD_ARB_PERF_CNT_EN
  logic [31:0] beats_q [NUM_MSTR];
  logic [31:0] stall_q [NUM_MSTR];

  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      for (int i = 0; i < NUM_MSTR; i++) begin
        beats_q[i] <= '0;
        stall_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MSTR; i++) begin
        if (s_rvalid[i] && s_rready[i]) beats_q[i] <= beats_q[i] + 32'd1;
        if (s_arvalid[i] && !arready_q[i]) stall_q[i] <= stall_q[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_MSTR; g++) begin : g_perf
    assign perf_beats[g*32 +: 32] = beats_q[g];
    assign perf_stall[g*32 +: 32] = stall_q[g];
  end
`else
  assign perf_beats = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_cl_ddr_rd_arb.sv
// -----------------------------------------------------------------------------
// tb_cl_ddr_rd_arb
//   Directed bench for cl_ddr_rd_arb with three masters, MAX_OUTST=4 and
//   ID_W=6 (DDR-side ID is 8 bits: {index[1:0], id[5:0]}).
//   Inputs change 1 ns after the rising edge. Outputs are sampled there, or
//   1 ns after a change to a combinational R-path input.
// -----------------------------------------------------------------------------
module tb_cl_ddr_rd_arb;
  localparam int NM = 3;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int IW = 6;
  localparam int MW = IW + 2;

  logic            clk = 1'b0;
  logic            pipe_rst_n = 1'b0;
  logic [NM-1:0]   s_arvalid = '0;
  logic [NM-1:0]   s_arready;
  logic [NM*AW-1:0] s_araddr = '0;
  logic [NM*IW-1:0] s_arid = '0;
  logic [NM*8-1:0] s_arlen = '0;
  logic [NM*3-1:0] s_arsize = '0;
  logic [NM-1:0]   s_rvalid;
  logic [NM-1:0]   s_rready = '0;
  logic [DW-1:0]   s_rdata;
  logic [IW-1:0]   s_rid;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
  logic [AW-1:0]   m_araddr;
  logic [MW-1:0]   m_arid;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic            m_rvalid = 1'b0;
  logic            m_rready;
  logic [DW-1:0]   m_rdata = '0;
  logic [MW-1:0]   m_rid = '0;
  logic [1:0]      m_rresp = '0;
  logic            m_rlast = 1'b0;
  logic            route_err;
  logic [NM*32-1:0] perf_beats;
  logic [NM*32-1:0] perf_stall;

  int n_tests = 0;
  int n_fail  = 0;

  cl_ddr_rd_arb #(
    .NUM_MSTR (NM), .ADDR_W (AW), .DATA_W (DW), .ID_W (IW), .MAX_OUTST (4)
  ) dut (
    .clk (clk), .pipe_rst_n (pipe_rst_n),
    .s_arvalid (s_arvalid), .s_arready (s_arready), .s_araddr (s_araddr),
    .s_arid (s_arid), .s_arlen (s_arlen), .s_arsize (s_arsize),
    .s_rvalid (s_rvalid), .s_rready (s_rready), .s_rdata (s_rdata),
    .s_rid (s_rid), .s_rresp (s_rresp), .s_rlast (s_rlast),
    .m_arvalid (m_arvalid), .m_arready (m_arready), .m_araddr (m_araddr),
    .m_arid (m_arid), .m_arlen (m_arlen), .m_arsize (m_arsize),
    .m_rvalid (m_rvalid), .m_rready (m_rready), .m_rdata (m_rdata),
    .m_rid (m_rid), .m_rresp (m_rresp), .m_rlast (m_rlast),
    .route_err (route_err), .perf_beats (perf_beats), .perf_stall (perf_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [MW-1:0]  exp_id [4];
    logic [NM-1:0]  exp_rdy [4];

    // ---- reset state
    tick(); tick();
    check("rst_arready", s_arready, 0);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_route_err", route_err, 0);
    check("rst_rvalid", s_rvalid, 0);
    pipe_rst_n = 1'b1;
    tick();

    // ---- single master 0: ARLEN=3, ID=5, addr 0x1000
    s_arvalid = 3'b001;
    s_araddr[0 +: AW] = 64'h1000;
    s_arid[0 +: IW] = 6'd5;
    s_arlen[0 +: 8] = 8'd3;
    s_arsize[0 +: 3] = 3'd2;
    tick();
    check("t1_arready", s_arready, 3'b001);
    check("t1_arvalid_pre", m_arvalid, 0);
    tick();
    check("t1_arvalid", m_arvalid, 1);
    check("t1_araddr", m_araddr, 64'h1000);
    check("t1_arid", m_arid, 8'h05);
    check("t1_arlen", m_arlen, 3);
    check("t1_arsize", m_arsize, 2);
    check("t1_arready_drop", s_arready, 0);
    s_arvalid = '0;
    tick();
    check("t1_hold_valid", m_arvalid, 1);
    check("t1_hold_addr", m_araddr, 64'h1000);
    m_arready = 1'b1;
    tick();
    check("t1_ar_done", m_arvalid, 0);

    m_rvalid = 1'b1;
    m_rid = 8'h05;
    m_rdata = 32'hA0;
    s_rready = '0;
    #1;
    check("t1_backpressure", m_rready, 0);
    s_rready = '1;
    for (int b = 0; b < 4; b++) begin
      m_rdata = 32'hA0 + 32'(b);
      m_rresp = 2'(b);
      m_rlast = (b == 3);
      #1;
      check("t1_rvalid", s_rvalid, 3'b001);
      check("t1_rid", s_rid, 5);
      check("t1_rdata", s_rdata, 32'hA0 + b);
      check("t1_rresp", s_rresp, b);
      check("t1_rlast", s_rlast, (b == 3));
      check("t1_mrready", m_rready, 1);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
`ifdef RD_ARB_PERF_CNT_EN
    check("t1_perf_beats0", perf_beats[31:0], 4);
    check("t1_perf_stall0", perf_stall[31:0], 1);
`else
    check("t1_perf_beats_off", perf_beats, 0);
    check("t1_perf_stall_off", perf_stall, 0);
`endif

    // ---- M0 and M1 both requesting: pointer is 1 after the first grant
    exp_id[0] = 8'h42; exp_rdy[0] = 3'b010;
    exp_id[1] = 8'h01; exp_rdy[1] = 3'b001;
    exp_id[2] = 8'h42; exp_rdy[2] = 3'b010;
    exp_id[3] = 8'h01; exp_rdy[3] = 3'b001;
    s_arid[0 +: IW] = 6'd1;
    s_arid[IW +: IW] = 6'd2;
    s_arvalid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_arready", s_arready, exp_rdy[k]);
      check("t2_gap", m_arvalid, 0);
      tick();
      check("t2_arvalid", m_arvalid, 1);
      check("t2_arid", m_arid, exp_id[k]);
    end
    s_arvalid = '0;
    tick();
    check("t2_idle", m_arvalid, 0);

    // ---- drain: route rlasts back to M0 (rid 0x01) and M1 (rid 0x42)
    m_rlast = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_rvalid = 1'b1;
      m_rid = (k < 2) ? 8'h01 : 8'h42;
      #1;
      check("t3_rvalid", s_rvalid, (k < 2) ? 3'b001 : 3'b010);
      check("t3_rid", s_rid, (k < 2) ? 1 : 2);
      tick();
      m_rvalid = 1'b0;
    end

    // ---- outstanding limit: M0 alone, four ARs fill it
    s_arid[0 +: IW] = 6'd7;
    s_araddr[0 +: AW] = 64'h2000;
    s_arvalid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_arready", s_arready, 3'b001);
      tick();
      check("t4_arvalid", m_arvalid, 1);
      check("t4_arid", m_arid, 8'h07);
    end
    tick();
    check("t4_full_a", s_arready, 0);
    check("t4_full_valid", m_arvalid, 0);
    tick();
    check("t4_full_b", s_arready, 0);
    m_rvalid = 1'b1;
    m_rid = 8'h07;
    #1;
    check("t4_rl_route", s_rvalid, 3'b001);
    tick();
    m_rvalid = 1'b0;
    check("t4_still_blocked", s_arready, 0);
    tick();
    check("t4_5th_granted", s_arready, 3'b001);
    // rlast in the same cycle as the grant handshake: count stays at 3
    m_rvalid = 1'b1;
    tick();
    m_rvalid = 1'b0;
    check("t4_5th_issued", m_arvalid, 1);
    tick();
    check("t4_same_cycle", s_arready, 3'b001);
    tick();
    check("t4_6th_issued", m_arvalid, 1);
    tick();
    check("t4_full_again", s_arready, 0);
    s_arvalid = '0;
    m_rlast = 1'b0;
    tick();

    // ---- index 3 with three masters: dropped, sticky error
    check("t5_err_pre", route_err, 0);
    s_rready = '0;
    m_rvalid = 1'b1;
    m_rid = 8'hC1;
    #1;
    check("t5_mrready", m_rready, 1);
    check("t5_no_rvalid", s_rvalid, 0);
    tick();
    m_rvalid = 1'b0;
    check("t5_err_set", route_err, 1);
    tick(); tick();
    check("t5_err_sticky", route_err, 1);

    // ---- asynchronous reset while an AR is held on the DDR port
    m_arready = 1'b0;
    s_arid[IW +: IW] = 6'h2A;
    s_arvalid = 3'b010;
    tick();
    check("t6_arready", s_arready, 3'b010);
    tick();
    check("t6_arvalid", m_arvalid, 1);
    check("t6_arid", m_arid, 8'h6A);
    pipe_rst_n = 1'b0;
    #1;
    check("t6_rst_arvalid", m_arvalid, 0);
    check("t6_rst_arready", s_arready, 0);
    check("t6_rst_err", route_err, 0);
    check("t6_rst_perf_beats", perf_beats, 0);
    check("t6_rst_perf_stall", perf_stall, 0);
    s_arvalid = '0;
    tick();
    pipe_rst_n = 1'b1;
    m_arready = 1'b1;
    tick();
    // pointer back at 0: all three requesting, M0 wins
    s_arvalid = 3'b111;
    tick();
    check("t6_ptr_reset", s_arready, 3'b001);
    s_arvalid = '0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
